// File: rtl/hamm_scrub_ctrl.sv
// Background scrubber for a DEPTH x 12-bit Hamming(12,8) codeword memory.
// Each pass reads every word, writes back single-bit corrections and counts errors.
module hamm_scrub_ctrl #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_add,
  output logic              mem_red_wr,
  output logic [11:0]       mem_wdata,
  input  logic [11:0]       mem_rdata,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic [ADDR_W-1:0] last_err_add
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CHK, S_WB, S_NEXT, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_wr;
  logic [11:0]       r_wdata;
  logic [CNT_W-1:0]  r_corr;
  logic [CNT_W-1:0]  r_uncorr;
  logic [ADDR_W-1:0] r_last;

  logic [3:0]        w_syn;
  logic [11:0]       w_flip;

  // Syndrome is the XOR of the Hamming positions (bit index + 1) of every set bit.
  always_comb begin
    w_syn = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (mem_rdata[i]) w_syn = w_syn ^ 4'(i + 1);
    end
    w_flip = 12'd1 << (w_syn - 4'd1);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr     <= 1'b0;
      r_wdata  <= '0;
      r_corr   <= '0;
      r_uncorr <= '0;
      r_last   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_corr   <= '0;
            r_uncorr <= '0;
            r_addr   <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RD;
          end
        end
        S_RD: r_state <= S_CHK;
        S_CHK: begin
          if (w_syn == 4'd0) begin
            r_state <= S_NEXT;
          end else if (w_syn <= 4'd12) begin
            r_wdata <= mem_rdata ^ w_flip;
            r_last  <= r_addr;
            r_wr    <= 1'b1;
            r_state <= S_WB;
          end else begin
            // Syndromes 13..15 point outside the codeword: a multi-bit error.
            if (r_uncorr != CNT_MAX) r_uncorr <= r_uncorr + CNT_ONE;
            r_last  <= r_addr;
            r_state <= S_NEXT;
          end
        end
        S_WB: begin
          r_wr    <= 1'b0;
          if (r_corr != CNT_MAX) r_corr <= r_corr + CNT_ONE;
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (r_addr == LAST_ADDR) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + ADDR_ONE;
            r_state <= S_RD;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign mem_add      = r_addr;
  assign mem_red_wr   = r_wr;
  assign mem_wdata    = r_wdata;
  assign corr_cnt     = r_corr;
  assign uncorr_cnt   = r_uncorr;
  assign last_err_add = r_last;

endmodule

// File: tb/tb_hamm_scrub_ctrl.sv
// Self-checking bench for hamm_scrub_ctrl: a 16-word memory model plus a per-pass
// expected trace derived from each word's syndrome and the per-word cycle costs.
module tb_hamm_scrub_ctrl;

  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 3;
  localparam int DEPTH   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       wr;
    logic [3:0] add;
    logic [11:0] wdata;
  } obs_t;

  logic              clk;
  logic              clr;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] memAdd;
  logic              memWr;
  logic [11:0]       memWdata;
  logic [11:0]       memRdata;
  logic [CNT_W-1:0]  corrCnt;
  logic [CNT_W-1:0]  uncorrCnt;
  logic [ADDR_W-1:0] lastErrAdd;

  logic [11:0] mem [DEPTH];
  logic [11:0] loadImg [DEPTH];
  logic        loadEn;

  obs_t        trace [128];
  int          traceLen;
  int          doneAt;
  logic [11:0] expMem [DEPTH];
  int          expCorr;
  int          expUncorr;
  int          expLast;

  int checks;
  int failures;

  hamm_scrub_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .start(start), .busy(busy), .done(done),
    .mem_add(memAdd), .mem_red_wr(memWr), .mem_wdata(memWdata), .mem_rdata(memRdata),
    .corr_cnt(corrCnt), .uncorr_cnt(uncorrCnt), .last_err_add(lastErrAdd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with one-cycle read latency; bench loads an image through loadEn.
  always @(posedge clk) begin
    if (loadEn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= loadImg[i];
    end else if (memWr) begin
      mem[memAdd] <= memWdata;
    end
    memRdata <= mem[memAdd];
  end

  function automatic int syndrome(input logic [11:0] w);
    int s = 0;
    for (int i = 0; i < 12; i++) if (w[i]) s = s ^ (i + 1);
    return s;
  endfunction

  function automatic obs_t mkObs(input logic b, input logic d, input logic wr,
                                 input int add, input logic [11:0] wd);
    obs_t o;
    o.busy = b; o.done = d; o.wr = wr; o.add = 4'(add); o.wdata = wd;
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] base);
    for (int i = 0; i < DEPTH; i++) loadImg[i] = base;
  endtask

  task automatic loadMemory();
    loadEn = 1'b1;
    @(posedge clk);
    #1 loadEn = 1'b0;
  endtask

  // Expected behaviour of one pass over the current memory contents: per word RD+CHK,
  // an extra write cycle for syndromes 1..12, then NEXT; DONE after the last word.
  task automatic buildModel();
    int n = 1;
    int s;
    logic [11:0] w;
    logic [11:0] fixed;
    expCorr = 0;
    expUncorr = 0;
    for (int a = 0; a < DEPTH; a++) begin
      w = mem[a];
      s = syndrome(w);
      expMem[a] = w;
      trace[n] = mkObs(1'b1, 1'b0, 1'b0, a, 12'h000);
      trace[n+1] = mkObs(1'b1, 1'b0, 1'b0, a, 12'h000);
      n += 2;
      if (s >= 1 && s <= 12) begin
        fixed = w ^ (12'h001 << (s - 1));
        expMem[a] = fixed;
        trace[n] = mkObs(1'b1, 1'b0, 1'b1, a, fixed);
        n++;
        if (expCorr < CNT_MAX) expCorr++;
        expLast = a;
      end else if (s >= 13) begin
        if (expUncorr < CNT_MAX) expUncorr++;
        expLast = a;
      end
      trace[n] = mkObs(1'b1, 1'b0, 1'b0, a, 12'h000);
      n++;
    end
    trace[n] = mkObs(1'b1, 1'b1, 1'b0, DEPTH - 1, 12'h000);
    doneAt = n;
    trace[n+1] = mkObs(1'b0, 1'b0, 1'b0, DEPTH - 1, 12'h000);
    trace[n+2] = mkObs(1'b0, 1'b0, 1'b0, DEPTH - 1, 12'h000);
    traceLen = n + 2;
  endtask

  // Runs one pass, comparing every cycle against the trace; extra start pulses
  // are held high during cycles xA and xB (0 = none) and must be ignored.
  task automatic runPass(input string tag, input int xA, input int xB, input int litDone,
                         input int litCorr, input int litUncorr, input int litLast);
    int doneSeen = 0;
    obs_t got;
    buildModel();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= traceLen; n++) begin
      got = mkObs(busy, done, memWr, int'(memAdd), memWr ? memWdata : 12'h000);
      checkOutput($sformatf("%s_cyc%0d", tag, n), 32'(got), 32'(trace[n]));
      if (done && doneSeen == 0) doneSeen = n;
      start = (n + 1 == xA || n + 1 == xB) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checkOutput({tag, "_doneModel"}, doneSeen, doneAt);
    checkOutput({tag, "_doneLit"}, doneSeen, litDone);
    checkOutput({tag, "_corr"}, 32'(corrCnt), expCorr);
    checkOutput({tag, "_corrLit"}, 32'(corrCnt), litCorr);
    checkOutput({tag, "_uncorr"}, 32'(uncorrCnt), expUncorr);
    checkOutput({tag, "_uncorrLit"}, 32'(uncorrCnt), litUncorr);
    checkOutput({tag, "_last"}, 32'(lastErrAdd), expLast);
    checkOutput({tag, "_lastLit"}, 32'(lastErrAdd), litLast);
    for (int a = 0; a < DEPTH; a++)
      checkOutput($sformatf("%s_mem%0d", tag, a), 32'(mem[a]), 32'(expMem[a]));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    clr = 1'b0;
    start = 1'b0;
    loadEn = 1'b0;
    expLast = 0;

    checkOutput("pin_syn_4A9", syndrome(12'h4A9), 0);
    checkOutput("pin_syn_4AB", syndrome(12'h4AB), 2);
    checkOutput("pin_syn_CA8", syndrome(12'hCA8), 13);

    applyStimulus(12'h4A9);
    loadMemory();
    @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_wr", 32'(memWr), 0);
    checkOutput("rst_add", 32'(memAdd), 0);
    checkOutput("rst_wdata", 32'(memWdata), 0);
    checkOutput("rst_cnts", {corrCnt, uncorrCnt, lastErrAdd}, 0);
    #2 clr = 1'b1;
    @(posedge clk);
    #1;

    runPass("clean", 0, 0, 49, 0, 0, 0);

    applyStimulus(12'h4A9);
    loadImg[1] = 12'h4AB;
    loadMemory();
    runPass("w1", 0, 0, 50, 1, 0, 1);
    checkOutput("w1_memLit", 32'(mem[1]), 32'h4A9);

    applyStimulus(12'h4A9);
    loadImg[2] = 12'h4AD;
    loadMemory();
    runPass("w2", 0, 0, 50, 1, 0, 2);
    checkOutput("w2_memLit", 32'(mem[2]), 32'h4A9);
    runPass("w2again", 0, 0, 49, 0, 0, 2);

    applyStimulus(12'h4A9);
    loadImg[3] = 12'hCA8;
    loadMemory();
    runPass("w3", 0, 0, 49, 0, 1, 3);
    checkOutput("w3_memLit", 32'(mem[3]), 32'hCA8);

    applyStimulus(12'h4A9);
    loadMemory();
    runPass("restart", 10, 49, 49, 0, 0, 3);

    applyStimulus(12'h4A9);
    for (int a = 0; a < 10; a++) loadImg[a] = 12'h4A9 ^ (12'h001 << a);
    loadMemory();
    runPass("satCorr", 0, 0, 59, CNT_MAX, 0, 9);

    applyStimulus(12'h4A9);
    for (int a = 2; a < 12; a++) begin
      case (a % 3)
        0:       loadImg[a] = 12'hCA8;
        1:       loadImg[a] = 12'hCAB;
        default: loadImg[a] = 12'hCAD;
      endcase
    end
    loadMemory();
    runPass("satUncorr", 0, 0, 49, 0, CNT_MAX, 11);

    // Reset while the write-back of word 5 is on the bus.
    applyStimulus(12'h4A9);
    loadImg[5] = 12'h4B9;
    loadMemory();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    checkOutput("rstwb_wrBefore", 32'(memWr), 1);
    checkOutput("rstwb_addBefore", 32'(memAdd), 5);
    #2 clr = 1'b0;
    #1;
    checkOutput("rstwb_wrAsync", 32'(memWr), 0);
    repeat (2) @(posedge clk);
    #3 clr = 1'b1;
    expLast = 0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rstwb_busy", 32'(busy), 0);
    checkOutput("rstwb_done", 32'(done), 0);
    checkOutput("rstwb_corr", 32'(corrCnt), 0);
    checkOutput("rstwb_uncorr", 32'(uncorrCnt), 0);
    checkOutput("rstwb_last", 32'(lastErrAdd), 0);
    checkOutput("rstwb_mem5", 32'(mem[5]), 32'h4B9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
